// File: rtl/count_display_driver.sv
// count_display_driver
// Shows the upstream 4-bit count as a hex digit on digit 0 of a 4-digit
// multiplexed 7-segment display. Counts F->0 wrap-arounds of that count as a
// 3-digit BCD tally on digits 1..3. A sticky overflow flag is lit on the
// decimal point of digit 3. All display pins are driven from registers.
module count_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cnt_in,
    input  logic        clr,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        wrap_pulse,
    output logic [11:0] tally_bcd,
    output logic        ovf
);

    // Width of the digit-slot prescaler; SCAN_DIV >= 2 keeps this at least 1.
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    // Segment pattern {g,f,e,d,c,b,a}, active low, for one hex/BCD digit.
    function automatic logic [6:0] hex_glyph(input logic [3:0] val);
        logic [6:0] g;
        case (val)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // One BCD digit plus one; a 9 rolls to 0 with the carry reported.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
        logic [4:0] r;
        if (digit >= 4'd9) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, digit + 4'd1};
        end
        return r;
    endfunction

    // Input pipeline and wrap detection
    logic [3:0] s1_r;
    logic [3:0] s2_r;
    logic       det_s;
    logic       wrap_pulse_r;

    // Tally state
    logic [3:0] ones_r;
    logic [3:0] tens_r;
    logic [3:0] hund_r;
    logic       ovf_r;
    logic [3:0] ones_nx_s;
    logic [3:0] tens_nx_s;
    logic [3:0] hund_nx_s;
    logic       ovf_nx_s;

    // Scan state
    logic [PW-1:0] prescaler_r;
    logic [PW-1:0] prescaler_nx_s;
    logic          tick_s;
    logic [1:0]    idx_r;
    logic [1:0]    idx_nx_s;

    // Display output registers and their next values
    logic [6:0] seg_r;
    logic       dp_r;
    logic [3:0] an_r;
    logic [6:0] seg_nx_s;
    logic       dp_nx_s;
    logic [3:0] an_nx_s;

    // A wrap is the count moving from F straight to 0 between two samples.
    always_comb begin
        det_s = (s1_r == 4'h0) && (s2_r == 4'hF);
    end

    // Two-stage capture of the upstream count; s2 is also the value displayed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r         <= 4'h0;
            s2_r         <= 4'h0;
            wrap_pulse_r <= 1'b0;
        end else begin
            s1_r         <= cnt_in;
            s2_r         <= s1_r;
            wrap_pulse_r <= det_s;
        end
    end

    // Next tally: clear has priority, otherwise ripple-carry BCD increment on a wrap.
    always_comb begin
        ones_nx_s = ones_r;
        tens_nx_s = tens_r;
        hund_nx_s = hund_r;
        ovf_nx_s  = ovf_r;
        if (clr) begin
            ones_nx_s = 4'd0;
            tens_nx_s = 4'd0;
            hund_nx_s = 4'd0;
            ovf_nx_s  = 1'b0;
        end else if (det_s) begin
            {tens_nx_s[0], ones_nx_s} = {1'b0, 4'd0};
            if (bcd_inc(ones_r) == {1'b1, 4'd0}) begin
                ones_nx_s = 4'd0;
                if (bcd_inc(tens_r) == {1'b1, 4'd0}) begin
                    tens_nx_s = 4'd0;
                    if (bcd_inc(hund_r) == {1'b1, 4'd0}) begin
                        // 999 + 1 rolls to 000 and latches the overflow flag.
                        hund_nx_s = 4'd0;
                        ovf_nx_s  = 1'b1;
                    end else begin
                        hund_nx_s = bcd_inc(hund_r)[3:0];
                    end
                end else begin
                    tens_nx_s = bcd_inc(tens_r)[3:0];
                end
            end else begin
                ones_nx_s = bcd_inc(ones_r)[3:0];
                tens_nx_s = tens_r;
            end
        end else begin
            ones_nx_s = ones_r;
            tens_nx_s = tens_r;
            hund_nx_s = hund_r;
            ovf_nx_s  = ovf_r;
        end
    end

    // Tally and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_r <= 4'd0;
            tens_r <= 4'd0;
            hund_r <= 4'd0;
            ovf_r  <= 1'b0;
        end else begin
            ones_r <= ones_nx_s;
            tens_r <= tens_nx_s;
            hund_r <= hund_nx_s;
            ovf_r  <= ovf_nx_s;
        end
    end

    // Digit-slot prescaler and digit index; the index moves on the last prescaler count.
    always_comb begin
        tick_s = (prescaler_r == PRE_LAST);
        if (tick_s) begin
            prescaler_nx_s = {PW{1'b0}};
            idx_nx_s       = idx_r + 2'd1;
        end else begin
            prescaler_nx_s = prescaler_r + PW'(1);
            idx_nx_s       = idx_r;
        end
    end

    // Scan counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r <= {PW{1'b0}};
            idx_r       <= 2'd0;
        end else begin
            prescaler_r <= prescaler_nx_s;
            idx_r       <= idx_nx_s;
        end
    end

    // Digit select and glyph for the current slot; leading tally zeros are blanked.
    always_comb begin
        an_nx_s  = 4'b1111;
        seg_nx_s = 7'h7F;
        case (idx_r)
            2'd0: begin
                an_nx_s  = 4'b1110;
                seg_nx_s = hex_glyph(s2_r);
            end
            2'd1: begin
                an_nx_s  = 4'b1101;
                seg_nx_s = hex_glyph(ones_r);
            end
            2'd2: begin
                an_nx_s = 4'b1011;
                if ((hund_r == 4'd0) && (tens_r == 4'd0)) begin
                    seg_nx_s = 7'h7F;
                end else begin
                    seg_nx_s = hex_glyph(tens_r);
                end
            end
            2'd3: begin
                an_nx_s = 4'b0111;
                if (hund_r == 4'd0) begin
                    seg_nx_s = 7'h7F;
                end else begin
                    seg_nx_s = hex_glyph(hund_r);
                end
            end
            default: begin
                an_nx_s  = 4'b1111;
                seg_nx_s = 7'h7F;
            end
        endcase
        // The overflow flag is shown as the decimal point of the hundreds digit.
        if ((idx_r == 2'd3) && ovf_r) begin
            dp_nx_s = 1'b0;
        end else begin
            dp_nx_s = 1'b1;
        end
    end

    // Registered display pins; all segments and digits dark in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_nx_s;
            dp_r  <= dp_nx_s;
            an_r  <= an_nx_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign wrap_pulse = wrap_pulse_r;
    assign tally_bcd  = {hund_r, tens_r, ones_r};
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver (SCAN_DIV=4). Expected wrap events are queued
// when the count stimulus is driven and matched against wrap_pulse/tally/ovf.
module tb_count_display_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cnt_in;
    logic        clr;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        wrap_pulse;
    logic [11:0] tally_bcd;
    logic        ovf;

    always #5 clk = ~clk;

    count_display_driver #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .wrap_pulse (wrap_pulse),
        .tally_bcd  (tally_bcd),
        .ovf        (ovf)
    );

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int          cyc;
        logic [11:0] tally;
        logic        ovf;
    } wrap_exp_t;

    wrap_exp_t   sb_q[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          cyc       = 0;
    int          rel_cyc   = 0;
    int          exp_tally = 0;
    logic        exp_ovf   = 1'b0;
    logic [3:0]  prev_drv  = 4'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // One clock: advance, then match any wrap_pulse against the scoreboard.
    task automatic step();
        wrap_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) rel_cyc++;
        else rel_cyc = 0;
        if (sb_q.size() > 0 && !wrap_pulse && sb_q[0].cyc <= cyc) begin
            check_val("wrap_missing", 32'(wrap_pulse), 32'd1);
            void'(sb_q.pop_front());
        end else if (wrap_pulse) begin
            if (sb_q.size() == 0) begin
                check_val("wrap_unexpected", 32'(wrap_pulse), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("wrap_cycle", 32'(cyc), 32'(e.cyc));
                check_val("wrap_tally", 32'(tally_bcd), 32'(e.tally));
                check_val("wrap_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    endtask

    // Drive a new count; an F->0 step queues the wrap expected two edges later.
    task automatic drive_cnt(input logic [3:0] v, input bit clr_hit);
        wrap_exp_t e;
        cnt_in = v;
        if (prev_drv == 4'hF && v == 4'h0) begin
            if (clr_hit) begin
                exp_tally = 0;
                exp_ovf   = 1'b0;
            end else if (exp_tally == 999) begin
                exp_tally = 0;
                exp_ovf   = 1'b1;
            end else begin
                exp_tally++;
            end
            e.cyc   = cyc + 2;
            e.tally = to_bcd(exp_tally);
            e.ovf   = exp_ovf;
            sb_q.push_back(e);
        end
        prev_drv = v;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        check_val("rst_an", 32'(an), 32'(4'b1111));
        check_val("rst_seg", 32'(seg), 32'(7'h7F));
        check_val("rst_dp", 32'(dp), 32'd1);
        check_val("rst_tally", 32'(tally_bcd), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_wrap", 32'(wrap_pulse), 32'd0);
        sb_q.delete();
        exp_tally = 0;
        exp_ovf   = 1'b0;
        rst_n     = 1'b1;
        prev_drv  = cnt_in;
    endtask

    // Check the scanned display for n cycles; count must be held steady beforehand.
    task automatic check_display(input int n);
        int         slot;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        repeat (n) begin
            step();
            slot = ((rel_cyc - 1) / 4) % 4;
            ea   = ~(4'b0001 << slot);
            case (slot)
                0:       es = GLYPH[cnt_in];
                1:       es = GLYPH[exp_tally % 10];
                2:       es = (exp_tally < 10) ? 7'h7F : GLYPH[(exp_tally / 10) % 10];
                default: es = (exp_tally < 100) ? 7'h7F : GLYPH[exp_tally / 100];
            endcase
            ed = (slot == 3 && exp_ovf) ? 1'b0 : 1'b1;
            check_val("disp_an", 32'(an), 32'(ea));
            check_val("disp_seg", 32'(seg), 32'(es));
            check_val("disp_dp", 32'(dp), 32'(ed));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        cnt_in = 4'h0;
        clr    = 1'b0;

        // 1: reset state and first digit after release
        apply_reset(5);
        step();
        check_val("release_an", 32'(an), 32'(4'b1110));

        // 2: full count sweep gives exactly one wrap, tally 001
        for (int v = 0; v < 16; v++) begin
            drive_cnt(4'(v), 1'b0);
            repeat (4) step();
        end
        drive_cnt(4'h0, 1'b0);
        repeat (4) step();
        check_val("sweep_tally", 32'(tally_bcd), 32'h001);
        check_val("sweep_drained", 32'(sb_q.size()), 32'd0);

        // 3: non-wrap transitions
        drive_cnt(4'hF, 1'b0);
        repeat (4) step();
        drive_cnt(4'h3, 1'b0);
        repeat (4) step();
        drive_cnt(4'hF, 1'b0);
        repeat (20) step();
        drive_cnt(4'h3, 1'b0);
        repeat (2) step();
        drive_cnt(4'h0, 1'b0);
        repeat (6) step();
        drive_cnt(4'hF, 1'b0);
        repeat (4) step();
        check_val("nowrap_tally", 32'(tally_bcd), 32'h001);

        // clear on its own
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_tally = 0;
        exp_ovf   = 1'b0;
        check_val("clr_tally", 32'(tally_bcd), 32'd0);
        check_val("clr_ovf", 32'(ovf), 32'd0);

        // 4: 1000 wraps roll the tally to 000 and set ovf
        for (int i = 0; i < 1000; i++) begin
            drive_cnt(4'hF, 1'b0);
            step();
            drive_cnt(4'h0, 1'b0);
            step();
        end
        repeat (3) step();
        check_val("roll_tally", 32'(tally_bcd), 32'h000);
        check_val("roll_ovf", 32'(ovf), 32'd1);
        check_val("roll_drained", 32'(sb_q.size()), 32'd0);
        check_display(16);

        // 5: clr coinciding with a wrap at tally 041
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_tally = 0;
        exp_ovf   = 1'b0;
        for (int i = 0; i < 41; i++) begin
            drive_cnt(4'hF, 1'b0);
            step();
            drive_cnt(4'h0, 1'b0);
            step();
        end
        drive_cnt(4'hF, 1'b0);
        repeat (3) step();
        check_val("pre_clr_tally", 32'(tally_bcd), 32'h041);
        drive_cnt(4'h0, 1'b1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_val("clrhit_tally", 32'(tally_bcd), 32'd0);
        step();
        check_val("clrhit_pulse_once", 32'(wrap_pulse), 32'd0);

        // 6: scan order and glyphs with tally 005, then reset in slot 2
        cnt_in = 4'h3;
        apply_reset(2);
        for (int i = 0; i < 5; i++) begin
            drive_cnt(4'hF, 1'b0);
            step();
            drive_cnt(4'h0, 1'b0);
            step();
        end
        drive_cnt(4'hA, 1'b0);
        repeat (4) step();
        check_val("scan_tally", 32'(tally_bcd), 32'h005);
        check_display(16);
        for (int i = 0; i < 16 && ((rel_cyc / 4) % 4) != 2; i++) step();
        apply_reset(1);
        step();
        check_val("rerelease_an", 32'(an), 32'(4'b1110));
        check_val("rerelease_seg", 32'(seg), 32'(GLYPH[0]));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
